// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshaking.
// One input word is steered by demux4_s into one of four single-entry
// slots. Each slot is drained independently by its own consumer. Input
// ready is pass-through: a full slot can take a new word in the same
// cycle it drains.
module demux4_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] demux4_d,
    input  logic [1:0]       demux4_s,
    input  logic             demux4_valid,
    output logic             demux4_ready,
    output logic [WIDTH-1:0] demux4_y0,
    output logic [WIDTH-1:0] demux4_y1,
    output logic [WIDTH-1:0] demux4_y2,
    output logic [WIDTH-1:0] demux4_y3,
    output logic [3:0]       demux4_yvalid,
    input  logic [3:0]       demux4_yready,
    output logic [2:0]       demux4_pending
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e      state_q [4];
    slot_state_e      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [2:0]       pending_q;
    logic [2:0]       pending_d;
    logic [3:0]       full;
    logic             acc;

    // Decode slot states into a full-flag vector.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full[i] = (state_q[i] == SLOT_FULL);
        end
    end

    // Ready looks only at the selected slot; it never depends on valid.
    // With valid low the select is a don't-care, since acc is then forced low.
    assign demux4_ready = ~full[demux4_s] | demux4_yready[demux4_s];
    assign acc          = demux4_valid & demux4_ready;

    // Per-slot next state: an accept wins over a drain (refill in place),
    // a drain alone empties the slot but keeps the stale data.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            if (acc && (demux4_s == 2'(i))) begin
                state_d[i] = SLOT_FULL;
                data_d[i]  = demux4_d;
            end else if (full[i] && demux4_yready[i]) begin
                state_d[i] = SLOT_EMPTY;
            end
        end
    end

    // Occupancy count is the popcount of the next full flags.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < 4; i++) begin
            pending_d = pending_d + 3'(state_d[i] == SLOT_FULL);
        end
    end

    // State registers; reset discards every held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= SLOT_EMPTY;
                data_q[i]  <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
            end
            pending_q <= pending_d;
        end
    end

    assign demux4_y0      = data_q[0];
    assign demux4_y1      = data_q[1];
    assign demux4_y2      = data_q[2];
    assign demux4_y3      = data_q[3];
    assign demux4_yvalid  = full;
    assign demux4_pending = pending_q;

endmodule

// File: tb/tb_demux4_reg.sv
// Self-checking bench for demux4_reg: directed scenarios followed by a
// randomized run, all compared against a slot-level reference model.
module tb_demux4_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d;
    logic [1:0]  s;
    logic        valid;
    logic        ready;
    logic [31:0] y0, y1, y2, y3;
    logic [3:0]  yvalid;
    logic [3:0]  yready;
    logic [2:0]  pending;

    int checks   = 0;
    int failures = 0;

    // Reference model: which slots hold a word, and what word.
    bit          m_full [4];
    logic [31:0] m_data [4];

    demux4_reg #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .demux4_d       (d),
        .demux4_s       (s),
        .demux4_valid   (valid),
        .demux4_ready   (ready),
        .demux4_y0      (y0),
        .demux4_y1      (y1),
        .demux4_y2      (y2),
        .demux4_y3      (y3),
        .demux4_yvalid  (yvalid),
        .demux4_yready  (yready),
        .demux4_pending (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] y_of(input int i);
        case (i)
            0:       return y0;
            1:       return y1;
            2:       return y2;
            default: return y3;
        endcase
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(m_full[i]);
        return n;
    endfunction

    // A slot can take a word when it is empty or being drained right now.
    function automatic bit m_ready(input int sel);
        return !m_full[sel] || yready[sel];
    endfunction

    // Check combinational ready against the model for the current select.
    task automatic chk_ready(input string tag);
        #1;
        chk({tag, ".ready"}, {31'b0, ready}, {31'b0, m_ready(int'(s))});
    endtask

    // Compare every registered output with the model.
    task automatic chk_outs(input string tag);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_full[i];
        chk({tag, ".yvalid"}, {28'b0, yvalid}, {28'b0, v});
        chk({tag, ".pending"}, {29'b0, pending}, 32'(m_count()));
        for (int i = 0; i < 4; i++) begin
            if (m_full[i] || m_data[i] == 32'h0)
                chk($sformatf("%s.y%0d", tag, i), y_of(i), m_data[i]);
        end
    endtask

    // Advance one clock: compute the model's next state from the current
    // inputs, clock the DUT, then commit the model.
    task automatic tick();
        bit          nf [4];
        logic [31:0] nd [4];
        bit          acc;
        acc = (valid === 1'b1) && m_ready(int'(s));
        for (int i = 0; i < 4; i++) begin
            nf[i] = m_full[i];
            nd[i] = m_data[i];
            if (reset) begin
                nf[i] = 1'b0;
                nd[i] = 32'h0;
            end else if (acc && int'(s) == i) begin
                nf[i] = 1'b1;
                nd[i] = d;
            end else if (m_full[i] && yready[i]) begin
                nf[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            m_full[i] = nf[i];
            m_data[i] = nd[i];
        end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; s = 2'd0; d = 32'h0; yready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = 32'h0;
        end
        tick();
        tick();
        chk_outs("reset");
        chk("reset.yvalid_const", {28'b0, yvalid}, 32'h0);
        reset = 1'b0;

        // Single accept into slot 2.
        valid = 1'b1; s = 2'd2; d = 32'hDEADBEEF; yready = 4'h0;
        chk_ready("acc2_pre");
        tick();
        chk_outs("acc2");
        chk("acc2.y2_const", y2, 32'hDEADBEEF);
        chk_ready("acc2_post");

        // Back-pressure on slot 2 for three cycles, then accept+drain together.
        d = 32'h1;
        for (int k = 0; k < 3; k++) begin
            chk_ready("bp");
            chk("bp.ready_low", {31'b0, ready}, 32'h0);
            tick();
            chk_outs("bp");
        end
        yready = 4'b0100;
        chk_ready("bp_release");
        tick();
        chk_outs("bp_release");
        chk("bp_release.y2", y2, 32'h1);
        chk("bp_release.pending", {29'b0, pending}, 32'd1);

        // Streaming with every consumer always ready.
        valid = 1'b0; yready = 4'hF;
        tick();
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1; s = 2'(k); d = 32'h10 + 32'(k);
            chk_ready("stream");
            tick();
            chk_outs("stream");
            chk("stream.y", y_of(k), 32'h10 + 32'(k));
            chk("stream.pending_le1", {31'b0, pending <= 3'd1}, 32'h1);
        end

        // Fill all four slots with no consumers.
        valid = 1'b0; yready = 4'hF;
        tick();
        yready = 4'h0; valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k); d = 32'hA0 + 32'(k);
            tick();
        end
        chk_outs("fill");
        chk("fill.pending4", {29'b0, pending}, 32'd4);
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            chk_ready("fill.full");
        end
        valid = 1'b0; yready = 4'b1010;
        tick();
        chk_outs("partial_drain");
        chk("partial_drain.yvalid", {28'b0, yvalid}, 32'h5);

        // Reset in the middle of operation with slots 1 and 3 full.
        yready = 4'hF;
        tick();
        yready = 4'h0; valid = 1'b1;
        s = 2'd1; d = 32'h111; tick();
        s = 2'd3; d = 32'h333; tick();
        chk_outs("pre_reset");
        reset = 1'b1; valid = 1'b1; s = 2'd0; d = 32'h55; yready = 4'hF;
        tick();
        reset = 1'b0; valid = 1'b0;
        chk_outs("mid_reset");
        chk("mid_reset.y1", y1, 32'h0);

        // Idle with an unknown select must not disturb state.
        yready = 4'h0; valid = 1'b1; s = 2'd2; d = 32'hCAFE;
        tick();
        valid = 1'b0; s = 2'bxx; d = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_outs("idle_x");
        end

        // Randomized traffic, including occasional reset.
        for (int k = 0; k < 400; k++) begin
            reset  = ($urandom_range(0, 49) == 0);
            valid  = 1'($urandom_range(0, 1));
            s      = 2'($urandom_range(0, 3));
            d      = $urandom;
            yready = 4'($urandom_range(0, 15));
            if (!reset) chk_ready("rand");
            tick();
            chk_outs("rand");
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
